div_sequencer: RTL and testbench
================================

# div_sequencer

Front-end sequencer for the 10-bit fixed-point divider. Accepts one operand pair per transaction over a valid/ready handshake and drives the divider's `ld_a`/`ld_b`/`start` controls. It waits the divider's fixed iteration latency, then captures `q`/`ov` into a held result with its own valid/ready handshake. Divide-by-zero is detected here and never reaches the divider.

## Interface
- `WIDTH`, 10: operand and quotient width; matches the divider.
- `DIV_LATENCY`, 14: cycles from the `div_start` pulse until divider `q`/`ov` are final; must be ≥ 2.
- `clk`  in  1  sole clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  sequencer can accept.
- `in_a`  in  WIDTH  dividend.
- `in_b`  in  WIDTH  divisor.
- `div_a`  out  WIDTH  dividend to divider `A`; registered.
- `div_b`  out  WIDTH  divisor to divider `B`; registered.
- `div_ld_a`  out  1  divider `ld_a`.
- `div_ld_b`  out  1  divider `ld_b`.
- `div_start`  out  1  divider `start`.
- `div_q`  in  WIDTH  divider quotient `q`.
- `div_ov`  in  1  divider overflow `ov`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_q`  out  WIDTH  quotient.
- `out_ov`  out  1  overflow flag.
- `out_dz`  out  1  divide-by-zero flag.

## Operation
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE
  - `in_ready`=1.
  - Accept on `in_valid & in_ready`: latch `in_a`/`in_b` into `div_a`/`div_b`.
  - If `in_b==0`: go to DONE with `out_q`=all ones, `out_ov`=1, `out_dz`=1; divider controls stay 0.
  - Else: go to LOAD.
- LOAD: `div_ld_a`=`div_ld_b`=1 for exactly one cycle; go to START.
- START: `div_start`=1 for exactly one cycle; clear wait counter to 0; go to WAIT.
- WAIT
  - Counter increments each cycle.
  - At the edge where counter == DIV_LATENCY-1: capture `div_q`→`out_q`, `div_ov`→`out_ov`, set `out_dz`=0; go to DONE.
- DONE
  - `out_valid`=1; `out_q`/`out_ov`/`out_dz` stable.
  - On `out_ready`: go to IDLE.
- `in_ready`=0 in every state except IDLE, so no new transaction is accepted while a result is pending.
- `div_a`/`div_b` hold their values from acceptance until the next acceptance.
- `in_a`/`in_b` are ignored outside the accepting edge.
- Controls are one-hot in time: `div_ld_*` and `div_start` are never high in the same cycle.

## Timing
- Reset (`rst`=0 at an edge):
  - State → IDLE; counter → 0.
  - `div_a`, `div_b`, `out_q` → 0; `out_ov`, `out_dz`, `out_valid` → 0.
  - `div_ld_a`, `div_ld_b`, `div_start` → 0.
  - `in_ready` is forced 0 while `rst`=0.
- Reset mid-transaction (any state): the transaction is abandoned with no output. The divider's internal state is cleared by its own reset; this block issues no further controls.
- Normal latency, with the acceptance edge as E0:
  - LOAD in the cycle after E0; START after E1; WAIT after E2.
  - DONE and `out_valid` after edge E(2+DIV_LATENCY), i.e. E16 by default.
- Divide-by-zero latency: `out_valid` high in the cycle after E0.
- `out_valid` and `out_ready` high on the same edge: the result is consumed and `out_valid` is 0 the following cycle.
- Back-to-back throughput: `in_ready` returns one cycle after consumption, giving at most one transaction per DIV_LATENCY+4 cycles.
- `out_ready` high while `out_valid`=0 has no effect.
- Wait counter width is `$clog2(DIV_LATENCY)`; it never wraps within one transaction.

## Structure
- Shared package `div_pkg` holds:
  - state enum `div_seq_state_t`;
  - `DIV_WIDTH`=10;
  - `DIV_LATENCY_DEFAULT`=14;
  - `DZ_QUOTIENT` (all ones).
- The divider top and the bench import the same constants from `div_pkg`.
- One sub-module, `seq_wait_counter`, provides the clear/enable counter with a terminal-count output at DIV_LATENCY-1.
- FSM, operand registers and result registers live in `div_sequencer`.

## Test plan
- **Basic division:** reset, then offer `in_a`=10'd40, `in_b`=10'd8 with `out_ready`=1.
  - `div_ld_a`/`div_ld_b` pulse one cycle after acceptance, then `div_start`.
  - `out_valid` arrives 16 cycles after acceptance; `out_q` equals a divider reference model, `out_dz`=0.
- **Divide by zero:** offer `in_b`=0, `in_a`=10'd123.
  - No `div_ld_*` or `div_start` pulse.
  - Next cycle `out_valid`=1, `out_q`=10'h3FF, `out_ov`=1, `out_dz`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Result stays stable and `in_ready` stays 0 while `in_valid` is held high.
  - Release `out_ready`: `out_valid` drops next cycle and `in_ready` rises.
- **Divider overflow passthrough:** stub divider returns `ov`=1, `q`=10'h3FF.
  - `out_ov`=1, `out_dz`=0, and the capture occurs exactly at counter value 13.
- **Reset mid-WAIT:** assert `rst`=0 at WAIT counter 5.
  - All outputs are 0 the next cycle; after release the state is IDLE with `in_ready`=1.
  - A fresh 40/8 transaction completes correctly.
- **Parameter sweep:** `DIV_LATENCY`=2 and 20.
  - `out_valid` arrives exactly DIV_LATENCY+2 edges after acceptance.
  - Back-to-back transactions are spaced DIV_LATENCY+4 cycles apart with `out_ready` tied high.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the fixed-point divider and its
// front-end sequencer.
package div_pkg;

  localparam int DIV_WIDTH           = 10;
  localparam int DIV_LATENCY_DEFAULT = 14;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } div_seq_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Operand, divider-control and result bundle of the divider sequencer.
// The slave side is the sequencer; the master side is its environment.
interface div_sequencer_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_ld_a;
  logic             div_ld_b;
  logic             div_start;
  logic [WIDTH-1:0] div_q;
  logic             div_ov;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_ov;
  logic             out_dz;

  modport slave (
    input  in_valid, in_a, in_b, div_q, div_ov, out_ready,
    output in_ready, div_a, div_b, div_ld_a, div_ld_b, div_start,
           out_valid, out_q, out_ov, out_dz
  );

  modport master (
    output in_valid, in_a, in_b, div_q, div_ov, out_ready,
    input  in_ready, div_a, div_b, div_ld_a, div_ld_b, div_start,
           out_valid, out_q, out_ov, out_dz
  );

endinterface

// File: rtl/seq_wait_counter.sv
// Clear/enable cycle counter; tc flags the last cycle of the divider
// iteration window (count == LATENCY-1).
module seq_wait_counter #(
  parameter int LATENCY = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(LATENCY - 1));

endmodule

// File: rtl/div_sequencer.sv
// Front-end sequencer: accepts an operand pair, pulses the divider loads and
// start, waits out the fixed iteration latency and holds the result.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  div_seq_state_t state, next;
  logic accept;
  logic b_zero;
  logic wait_done;

  assign accept = bus.in_valid & bus.in_ready;
  assign b_zero = (bus.in_b == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (accept) next = b_zero ? S_DONE : S_LOAD;
      S_LOAD:  next = S_START;
      S_START: next = S_WAIT;
      S_WAIT:  if (wait_done) next = S_DONE;
      S_DONE:  if (bus.out_ready) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Controls decode straight from the state register, so they are
  // one-hot in time and drop together with the state on reset.
  assign bus.in_ready  = rst & (state == S_IDLE);
  assign bus.div_ld_a  = (state == S_LOAD);
  assign bus.div_ld_b  = (state == S_LOAD);
  assign bus.div_start = (state == S_START);
  assign bus.out_valid = (state == S_DONE);

  seq_wait_counter #(
    .LATENCY (DIV_LATENCY)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (state == S_START),
    .en  (state == S_WAIT),
    .tc  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.div_a <= '0;
      bus.div_b <= '0;
    end else if (accept) begin
      bus.div_a <= bus.in_a;
      bus.div_b <= bus.in_b;
    end
  end

  // Divide-by-zero resolves at acceptance and bypasses the divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_q  <= '0;
      bus.out_ov <= 1'b0;
      bus.out_dz <= 1'b0;
    end else if (accept && b_zero) begin
      bus.out_q  <= '1;
      bus.out_ov <= 1'b1;
      bus.out_dz <= 1'b1;
    end else if (state == S_WAIT && wait_done) begin
      bus.out_q  <= bus.div_q;
      bus.out_ov <= bus.div_ov;
      bus.out_dz <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer at latencies 14, 2 and 20, each with a stub divider
// that only shows its final q/ov once the iteration latency has elapsed.
module tb_div_sequencer;
  import div_pkg::*;

  localparam int W  = DIV_WIDTH;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] in_valid;
  logic [NI-1:0] out_ready;
  logic [W-1:0]  in_a [NI];
  logic [W-1:0]  in_b [NI];
  logic          force_ov;

  wire  [NI-1:0] in_ready, out_valid, ld_a, ld_b, start, out_ov, out_dz;
  wire  [W-1:0]  out_q [NI];
  wire  [W-1:0]  div_a [NI];
  wire  [W-1:0]  div_b [NI];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? DIV_LATENCY_DEFAULT : (g == 1) ? 2 : 20;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(
      .WIDTH       (W),
      .DIV_LATENCY (LAT)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.in_valid  = in_valid[g];
    assign bus.in_a      = in_a[g];
    assign bus.in_b      = in_b[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign ld_a[g]       = bus.div_ld_a;
    assign ld_b[g]       = bus.div_ld_b;
    assign start[g]      = bus.div_start;
    assign out_q[g]      = bus.out_q;
    assign out_ov[g]     = bus.out_ov;
    assign out_dz[g]     = bus.out_dz;
    assign div_a[g]      = bus.div_a;
    assign div_b[g]      = bus.div_b;

    // Stub divider: outputs are complemented garbage until LAT cycles after start.
    logic [W-1:0] sa = '0;
    logic [W-1:0] sb = '0;
    int           scnt = 1000;
    logic [W-1:0] qfin;

    always @(posedge clk) begin
      if (bus.div_ld_a) sa <= bus.div_a;
      if (bus.div_ld_b) sb <= bus.div_b;
      if (bus.div_start)     scnt <= 0;
      else if (scnt < 1000)  scnt <= scnt + 1;
    end

    assign qfin       = force_ov ? '1 : ((sb == '0) ? '0 : sa / sb);
    assign bus.div_q  = (scnt >= LAT - 1) ? qfin : ~qfin;
    assign bus.div_ov = (scnt >= LAT - 1) ? force_ov : ~force_ov;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? DIV_LATENCY_DEFAULT : (k == 1) ? 2 : 20;
  endfunction

  // Expected {q, ov, dz} straight from the arithmetic rules.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic fov);
    if (b == '0) return {DZ_QUOTIENT, 2'b11};
    if (fov)     return {DZ_QUOTIENT, 2'b10};
    return {a / b, 2'b00};
  endfunction

  function automatic logic [W-1:0] rnd_b();
    return W'($urandom_range(1, (1 << W) - 1));
  endfunction

  // Offer one pair and observe until out_valid; returns at a negedge with the
  // result visible. Positions are counted in edges after the acceptance edge.
  task automatic drv_txn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int ld_at, output int st_at,
                         output int npulse, output int overlap);
    int n;
    @(negedge clk);
    in_a[k] = a; in_b[k] = b; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_a[k] = W'($urandom);
    in_b[k] = W'($urandom);
    lat = -1; ld_at = -1; st_at = -1; npulse = 0; overlap = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      if (out_valid[k]) begin lat = e; break; end
      if (ld_a[k] | ld_b[k] | start[k]) npulse++;
      if (ld_a[k] && ld_b[k] && ld_at < 0) ld_at = e;
      if (start[k] && st_at < 0) st_at = e;
      if ((ld_a[k] | ld_b[k]) && start[k]) overlap = 1;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== '0) begin bad++; $display("FAIL reset_in_ready got=%b want=000", in_ready); end
    total++; if (out_valid !== '0) begin bad++; $display("FAIL reset_out_valid got=%b want=000", out_valid); end
    total++; if ((ld_a | ld_b | start) !== '0) begin bad++; $display("FAIL reset_ctrl got=%b want=000", ld_a | ld_b | start); end
    total++; if ({div_a[0], div_b[0], out_q[0]} !== '0) begin bad++; $display("FAIL reset_regs got=%h/%h/%h want=0", div_a[0], div_b[0], out_q[0]); end
    total++; if ((out_ov | out_dz) !== '0) begin bad++; $display("FAIL reset_flags got=%b want=000", out_ov | out_dz); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== '1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=111", in_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] a, b, eq;
    logic eov, edz;
    int lat, ld_at, st_at, np, ovl;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? W'(40) : W'($urandom);
      b = (i == 0) ? W'(8)  : rnd_b();
      {eq, eov, edz} = ref_model(a, b, 1'b0);
      drv_txn(0, a, b, lat, ld_at, st_at, np, ovl);
      total++; if (lat !== DIV_LATENCY_DEFAULT + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, DIV_LATENCY_DEFAULT + 2); end
      total++; if (ld_at !== 0 || st_at !== 1) begin bad++; $display("FAIL basic_ctrl_pos got=ld%0d/st%0d want=ld0/st1", ld_at, st_at); end
      total++; if (np !== 2 || ovl !== 0) begin bad++; $display("FAIL basic_ctrl_count got=%0d/ovl%0d want=2/ovl0", np, ovl); end
      total++; if ({out_q[0], out_ov[0], out_dz[0]} !== {eq, eov, edz}) begin bad++; $display("FAIL basic_result a=%0d b=%0d got=%0d/%b/%b want=%0d/%b/%b", a, b, out_q[0], out_ov[0], out_dz[0], eq, eov, edz); end
      total++; if (div_a[0] !== a || div_b[0] !== b) begin bad++; $display("FAIL basic_operands got=%0d/%0d want=%0d/%0d", div_a[0], div_b[0], a, b); end
      @(posedge clk);
      @(negedge clk);
      total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin bad++; $display("FAIL basic_consume got=v%b/r%b want=v0/r1", out_valid[0], in_ready[0]); end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] a;
    int lat, ld_at, st_at, np, ovl;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? W'(123) : W'($urandom);
      drv_txn(0, a, '0, lat, ld_at, st_at, np, ovl);
      total++; if (lat !== 0) begin bad++; $display("FAIL dz_latency got=%0d want=0", lat); end
      total++; if (np !== 0) begin bad++; $display("FAIL dz_no_ctrl got=%0d want=0", np); end
      total++; if ({out_q[0], out_ov[0], out_dz[0]} !== {DZ_QUOTIENT, 2'b11}) begin bad++; $display("FAIL dz_result got=%h/%b/%b want=%h/1/1", out_q[0], out_ov[0], out_dz[0], DZ_QUOTIENT); end
      total++; if (div_a[0] !== a || div_b[0] !== '0) begin bad++; $display("FAIL dz_operands got=%0d/%0d want=%0d/0", div_a[0], div_b[0], a); end
      @(posedge clk);
      @(negedge clk);
      total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin bad++; $display("FAIL dz_consume got=v%b/r%b want=v0/r1", out_valid[0], in_ready[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, eq;
    logic eov, edz;
    int lat, ld_at, st_at, np, ovl;
    out_ready[0] = 1'b0;
    a = W'($urandom); b = rnd_b();
    {eq, eov, edz} = ref_model(a, b, 1'b0);
    drv_txn(0, a, b, lat, ld_at, st_at, np, ovl);
    in_a[0] = W'($urandom); in_b[0] = rnd_b(); in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d got=v%b/r%b want=v1/r0", i, out_valid[0], in_ready[0]); end
      total++; if ({out_q[0], out_ov[0], out_dz[0]} !== {eq, eov, edz}) begin bad++; $display("FAIL bp_stable cyc=%0d got=%0d want=%0d", i, out_q[0], eq); end
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_release got=v%b/r%b want=v0/r1", out_valid[0], in_ready[0]); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a, b;
    int lat, ld_at, st_at, np, ovl;
    force_ov = 1'b1;
    out_ready[0] = 1'b1;
    a = W'($urandom); b = rnd_b();
    drv_txn(0, a, b, lat, ld_at, st_at, np, ovl);
    total++; if (lat !== DIV_LATENCY_DEFAULT + 2) begin bad++; $display("FAIL ov_latency got=%0d want=%0d", lat, DIV_LATENCY_DEFAULT + 2); end
    total++; if ({out_q[0], out_ov[0], out_dz[0]} !== {DZ_QUOTIENT, 2'b10}) begin bad++; $display("FAIL ov_result got=%h/%b/%b want=%h/1/0", out_q[0], out_ov[0], out_dz[0], DZ_QUOTIENT); end
    @(posedge clk);
    #1 force_ov = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat, ld_at, st_at, np, ovl;
    out_ready[0] = 1'b1;
    @(negedge clk);
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL rmw_ready got=%b want=1", in_ready[0]); end
    in_a[0] = W'(40); in_b[0] = W'(8); in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if ((out_valid[0] | in_ready[0] | ld_a[0] | ld_b[0] | start[0]) !== 1'b0) begin bad++; $display("FAIL rmw_ctrl got=v%b/r%b/c%b want=0", out_valid[0], in_ready[0], ld_a[0] | ld_b[0] | start[0]); end
    total++; if ({div_a[0], div_b[0], out_q[0], out_ov[0], out_dz[0]} !== '0) begin bad++; $display("FAIL rmw_regs got=%h/%h/%h/%b/%b want=0", div_a[0], div_b[0], out_q[0], out_ov[0], out_dz[0]); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin bad++; $display("FAIL rmw_idle got=r%b/v%b want=r1/v0", in_ready[0], out_valid[0]); end
    drv_txn(0, W'(40), W'(8), lat, ld_at, st_at, np, ovl);
    total++; if (lat !== DIV_LATENCY_DEFAULT + 2 || out_q[0] !== W'(5) || out_dz[0] !== 1'b0) begin bad++; $display("FAIL rmw_fresh got=lat%0d/q%0d/dz%b want=lat%0d/q5/dz0", lat, out_q[0], out_dz[0], DIV_LATENCY_DEFAULT + 2); end
    @(posedge clk);
  endtask

  task automatic test_sweep();
    logic [W-1:0] a, b, eq;
    logic eov, edz;
    int lat, ld_at, st_at, np, ovl;
    for (int k = 1; k < NI; k++) begin
      out_ready[k] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        a = W'($urandom); b = rnd_b();
        {eq, eov, edz} = ref_model(a, b, 1'b0);
        drv_txn(k, a, b, lat, ld_at, st_at, np, ovl);
        total++; if (lat !== lat_of(k) + 2) begin bad++; $display("FAIL sweep_latency L=%0d got=%0d want=%0d", lat_of(k), lat, lat_of(k) + 2); end
        total++; if ({out_q[k], out_ov[k], out_dz[k]} !== {eq, eov, edz}) begin bad++; $display("FAIL sweep_result L=%0d got=%0d want=%0d", lat_of(k), out_q[k], eq); end
        total++; if (ld_at !== 0 || st_at !== 1 || np !== 2) begin bad++; $display("FAIL sweep_ctrl L=%0d got=ld%0d/st%0d/n%0d want=0/1/2", lat_of(k), ld_at, st_at, np); end
        @(posedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] eq;
    logic eov, edz;
    int last, nacc, budget;
    for (int k = 0; k < NI; k++) begin
      exp_q.delete();
      last = -1; nacc = 0;
      budget = 4 * (lat_of(k) + 4) + 10;
      out_ready[k] = 1'b1;
      @(negedge clk);
      in_a[k] = W'($urandom); in_b[k] = rnd_b(); in_valid[k] = 1'b1;
      for (int c = 0; c < budget; c++) begin
        if (c > 0) @(negedge clk);
        if (out_valid[k]) begin
          total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra L=%0d got=%0d want=none", lat_of(k), out_q[k]); end
          else begin
            eq = exp_q.pop_front();
            if (out_q[k] !== eq) begin bad++; $display("FAIL b2b_result L=%0d got=%0d want=%0d", lat_of(k), out_q[k], eq); end
          end
        end
        if (nacc == 3 && exp_q.size() == 0) break;
        if (in_valid[k] && in_ready[k]) begin
          if (last >= 0) begin
            total++; if (c - last !== lat_of(k) + 4) begin bad++; $display("FAIL b2b_spacing L=%0d got=%0d want=%0d", lat_of(k), c - last, lat_of(k) + 4); end
          end
          last = c;
          {eq, eov, edz} = ref_model(in_a[k], in_b[k], 1'b0);
          exp_q.push_back(eq);
          nacc++;
        end else begin
          in_valid[k] = (nacc < 3);
          in_a[k] = W'($urandom); in_b[k] = rnd_b();
        end
        @(posedge clk);
      end
      in_valid[k] = 1'b0;
      total++; if (nacc !== 3 || exp_q.size() !== 0) begin bad++; $display("FAIL b2b_count L=%0d got=acc%0d/pend%0d want=acc3/pend0", lat_of(k), nacc, exp_q.size()); end
    end
  endtask

  initial begin
    in_valid = '0;
    out_ready = '0;
    force_ov = 1'b0;
    for (int i = 0; i < NI; i++) begin in_a[i] = '0; in_b[i] = '0; end
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_overflow();
    test_reset_mid_wait();
    test_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
